// File: rtl/alarm_ctrl.sv
// Alarm-clock control FSM: owns alarm setting and arm flag, sequences time
// setting through a load pulse, and runs ring/snooze/timeout on alarm match.
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned CNT_W      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_arm,
  input  logic       btn_snooze,
  input  logic       btn_off,
  input  logic [3:0] qh1,
  input  logic [3:0] qh0,
  input  logic [3:0] qm1,
  input  logic [3:0] qm0,
  input  logic [3:0] qs1,
  input  logic [3:0] qs0,
  output logic [3:0] ah1,
  output logic [3:0] ah0,
  output logic [3:0] am1,
  output logic [3:0] am0,
  output logic [3:0] th1,
  output logic [3:0] th0,
  output logic [3:0] tm1,
  output logic [3:0] tm0,
  output logic       time_load,
  output logic       alarm_en,
  output logic       ringing,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_AH = 3'd1,
    SET_AM = 3'd2,
    SET_TH = 3'd3,
    SET_TM = 3'd4,
    RING   = 3'd5,
    SNOOZE = 3'd6
  } state_t;

  state_t           st;
  logic [7:0]       alarm_h;
  logic [7:0]       alarm_m;
  logic [7:0]       time_h;
  logic [7:0]       time_m;
  logic [CNT_W-1:0] cnt;
  logic             match;

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Hours wrap 23 -> 00; units digit carries into tens at 9.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    if (h == 8'h23)
      return 8'h00;
    else if (h[3:0] == 4'd9)
      return {h[7:4] + 4'd1, 4'd0};
    else
      return {h[7:4], h[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m[3:0] == 4'd9)
      return (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
    else
      return {m[7:4], m[3:0] + 4'd1};
  endfunction

  assign match = tick_1hz &&
                 ({qh1, qh0, qm1, qm0} == {alarm_h, alarm_m}) &&
                 ({qs1, qs0} == 8'h00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      alarm_h   <= '0;
      alarm_m   <= '0;
      time_h    <= '0;
      time_m    <= '0;
      cnt       <= '0;
      alarm_en  <= 1'b0;
      ringing   <= 1'b0;
      time_load <= 1'b0;
    end else begin
      time_load <= 1'b0;
      case (st)
        IDLE: begin
          if (btn_arm)
            alarm_en <= ~alarm_en;
          if (match && alarm_en) begin
            st      <= RING;
            cnt     <= RING_LOAD;
            ringing <= 1'b1;
          end else if (btn_mode) begin
            st <= SET_AH;
          end
        end
        SET_AH: begin
          if (btn_mode)     st      <= SET_AM;
          else if (btn_inc) alarm_h <= hour_inc(alarm_h);
        end
        SET_AM: begin
          if (btn_mode) begin
            st     <= SET_TH;
            time_h <= {qh1, qh0};
            time_m <= {qm1, qm0};
          end else if (btn_inc) begin
            alarm_m <= min_inc(alarm_m);
          end
        end
        SET_TH: begin
          if (btn_mode)     st     <= SET_TM;
          else if (btn_inc) time_h <= hour_inc(time_h);
        end
        SET_TM: begin
          if (btn_mode) begin
            st        <= IDLE;
            time_load <= 1'b1;
          end else if (btn_inc) begin
            time_m <= min_inc(time_m);
          end
        end
        RING: begin
          if (btn_off) begin
            st      <= IDLE;
            ringing <= 1'b0;
          end else if (btn_snooze) begin
            st      <= SNOOZE;
            cnt     <= SNOOZE_LOAD;
            ringing <= 1'b0;
          end else if (tick_1hz && cnt == CNT_ONE) begin
            st      <= IDLE;
            ringing <= 1'b0;
          end else if (tick_1hz) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        SNOOZE: begin
          if (btn_off) begin
            st <= IDLE;
          end else if (tick_1hz && cnt == CNT_ONE) begin
            st      <= RING;
            cnt     <= RING_LOAD;
            ringing <= 1'b1;
          end else if (tick_1hz) begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          st      <= IDLE;
          ringing <= 1'b0;
        end
      endcase
    end
  end

  assign {ah1, ah0} = alarm_h;
  assign {am1, am0} = alarm_m;
  assign {th1, th0} = time_h;
  assign {tm1, tm0} = time_m;
  assign state      = st;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Control FSM for the digital alarm clock.
- Owns the alarm-set registers (ah1/ah0/am1/am0) and the arm flag.
- Sequences user time-setting of the time-keeping counter through a load interface.
- Detects the alarm match against the running BCD time and drives ringing, snooze and timeout.
- Sits between the debounced button front-end and the time-keeping counter.

Parameters:
RING_SEC, 60, seconds ringing lasts before auto-stop
SNOOZE_SEC, 300, seconds spent in snooze before re-ringing
CNT_W, 10, width of ring/snooze second counter (must hold max(RING_SEC, SNOOZE_SEC))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
tick_1hz  in  1  one-cycle pulse per second, same pulse that advances the time counter
btn_mode  in  1  one-cycle pulse: step setting mode
btn_inc  in  1  one-cycle pulse: increment field being set
btn_arm  in  1  one-cycle pulse: toggle alarm_en (IDLE only)
btn_snooze  in  1  one-cycle pulse: snooze while ringing
btn_off  in  1  one-cycle pulse: stop alarm
qh1,qh0,qm1,qm0,qs1,qs0  in  4 each  current BCD time from time counter
ah1,ah0,am1,am0  out  4 each  alarm setting, BCD
th1,th0,tm1,tm0  out  4 each  time value to load, BCD
time_load  out  1  one-cycle pulse: counter loads th:tm, seconds := 00
alarm_en  out  1  alarm armed
ringing  out  1  alarm sounding
state  out  3  encoded FSM state, for display mux

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE; ah*=am*=th*=tm*=0; alarm_en=0; ringing=0; time_load=0; counter=0.
- All updates occur on posedge clk.
- States and codes: IDLE=0, SET_AH=1, SET_AM=2, SET_TH=3, SET_TM=4, RING=5, SNOOZE=6. Code 7 → IDLE next cycle.
- Mode cycle, btn_mode only: IDLE→SET_AH→SET_AM→SET_TH→SET_TM→IDLE.
  - Entering SET_TH copies qh1,qh0,qm1,qm0 into th/tm.
  - Leaving SET_TM: time_load=1 for exactly that one cycle, with th/tm stable.
- btn_inc behaviour by state:
  - SET_AH, SET_TH: hour field +1 BCD, 23→00; 09→10, 19→20.
  - SET_AM, SET_TM: minute field +1 BCD, 59→00; x9→(x+1)0.
  - Other states: ignored.
- btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
- btn_arm toggles alarm_en in IDLE only; it is ignored elsewhere.
- Match condition: {qh1,qh0,qm1,qm0}=={ah1,ah0,am1,am0} and {qs1,qs0}==00, with tick_1hz=1.
  - In IDLE with alarm_en=1, a match → RING next cycle and counter := RING_SEC.
  - A match during SET_* states is missed; no deferred ring.
- RING: ringing=1 (registered, asserted in the first RING cycle).
  - Exits, priority order: btn_off → IDLE; else btn_snooze → SNOOZE, counter := SNOOZE_SEC; else tick_1hz with counter==1 → IDLE; else tick_1hz → counter−1.
- SNOOZE: ringing=0.
  - btn_off → IDLE; else tick_1hz with counter==1 → RING, counter := RING_SEC; else tick_1hz → counter−1. btn_snooze is ignored.
- btn_mode and btn_inc are ignored in RING and SNOOZE. A new match while in SNOOZE/RING does not restart the counter.
- Exit to IDLE never clears alarm_en; the alarm recurs daily.
- Asserting rst mid-ring: ringing drops immediately (async); the alarm setting is lost.
- Inputs are not range-checked; the time counter guarantees valid BCD.

Test Plan:
- Reset then alarm set: rst low 3 cycles, release.
  - Then btn_mode, btn_inc ×7, btn_mode, btn_inc ×30, btn_mode ×3.
  - Required: ah=07, am=30, state back to IDLE.
  - Required: exactly one time_load pulse, with th/tm equal to the time captured on SET_TH entry.
- BCD wrap: in SET_AH from 23, btn_inc → 00. In SET_AM from 59 → 00. From 09 → 10.
- Ring with timeout (RING_SEC=3): alarm 00:01 armed, time 00:00:59 then tick.
  - Required: ringing=1 the cycle after qs=00 with tick.
  - Required: ringing=0 after 3 further ticks.
  - Required: no re-ring at qs=01.
- Snooze (SNOOZE_SEC=2): while ringing, btn_snooze → ringing=0.
  - After 2 ticks, ringing=1 again with a fresh RING_SEC.
  - btn_off → IDLE, alarm_en still 1.
- Simultaneous events:
  - btn_off with btn_snooze in RING → IDLE.
  - btn_mode with btn_inc in SET_AM → SET_TH, am unchanged.
  - btn_arm in SET_AH → alarm_en unchanged.
- Disarmed and async reset:
  - alarm_en=0 with a match → no ring.
  - rst asserted mid-RING between clock edges → ringing=0 and state=0 without waiting for a clock edge.
